// File: rtl/connect4_pkg.sv
// Shared constants and types for the Connect-4 player-2 SPI move receiver.
package connect4_pkg;

  localparam int          SPI_FRAME_W      = 8;
  localparam logic [2:0]  SPI_HEADER       = 3'b101;
  localparam int          NUM_COLS_DEFAULT = 7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } rx_state_t;

  // True when the frame holds an odd number of ones.
  function automatic logic parity_odd(input logic [SPI_FRAME_W-1:0] frame);
    return ^frame;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Parameterised-depth flop chain bringing one asynchronous bit into the clk domain.
module bit_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {STAGES{RESET_VAL}};
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_move_receiver.sv
// SPI mode-0 slave receiving one 8-bit move frame per CS window for player 2.
// Optional parity check is enabled by defining SPI_PARITY_EN.
module spi_move_receiver
  import connect4_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_COLS    = NUM_COLS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs,
  input  logic       enable,
  input  logic       clear,
  output logic [2:0] selected_col,
  output logic       valid_move,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [3:0] CNT_FULL   = 4'(SPI_FRAME_W);
  localparam logic [3:0] CNT_SAT    = 4'(SPI_FRAME_W + 1);
  localparam logic [3:0] COLS_LIMIT = 4'(NUM_COLS);
  localparam logic [1:0] SETTLE     = 2'(SYNC_STAGES);

  logic cs_s, sclk_s, mosi_s;

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst), .d(spi_cs), .q(cs_s)
  );
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst_n(rst), .d(spi_clk), .q(sclk_s)
  );
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst), .d(spi_mosi), .q(mosi_s)
  );

  logic       cs_d, sclk_d, mosi_d;
  logic       cs_fall_q, cs_rise_q, sclk_rise_q;
  logic [1:0] settle_cnt;
  logic       armed;

  // CS edges are ignored until the chain has flushed its reset value and CS
  // has really been seen high, so a reset released mid-frame cannot start one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_d        <= 1'b1;
      sclk_d      <= 1'b0;
      mosi_d      <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      settle_cnt  <= '0;
      armed       <= 1'b0;
    end else begin
      cs_d        <= cs_s;
      sclk_d      <= sclk_s;
      mosi_d      <= mosi_s;
      cs_fall_q   <= armed &  cs_d & ~cs_s;
      cs_rise_q   <= armed & ~cs_d &  cs_s;
      sclk_rise_q <= ~sclk_d & sclk_s;
      if (settle_cnt != SETTLE) settle_cnt <= settle_cnt + 2'd1;
      else if (cs_s)            armed      <= 1'b1;
    end
  end

  rx_state_t              state;
  logic [SPI_FRAME_W-1:0] shreg;
  logic [3:0]             bit_cnt;
  logic                   start_pending;
  logic                   parity_ok;
  logic                   frame_ok;

`ifdef SPI_PARITY_EN
  assign parity_ok = parity_odd(shreg);
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_ok = (bit_cnt == CNT_FULL) && (shreg[7:5] == SPI_HEADER) &&
                    !shreg[1] && ({1'b0, shreg[4:2]} < COLS_LIMIT) && parity_ok;

  assign busy = (state != IDLE);

  // NOTE: the shift register is ordinary control state, not a memory array,
  // so it takes the async reset like everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      start_pending <= 1'b0;
      selected_col  <= '0;
      valid_move    <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      valid_move  <= 1'b0;
      frame_error <= 1'b0;
      if (clear) begin
        state         <= IDLE;
        shreg         <= '0;
        bit_cnt       <= '0;
        start_pending <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cs_fall_q || start_pending) begin
              shreg         <= '0;
              bit_cnt       <= '0;
              start_pending <= 1'b0;
              state         <= SHIFT;
            end
          end
          SHIFT: begin
            if (sclk_rise_q) begin
              shreg <= {shreg[SPI_FRAME_W-2:0], mosi_d};
              if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 4'd1;
            end
            if (cs_rise_q) state <= CHECK;
          end
          CHECK: begin
            // A well-formed frame while disabled is dropped without any pulse.
            if (frame_ok && enable) begin
              selected_col <= shreg[4:2];
              valid_move   <= 1'b1;
            end else if (!frame_ok) begin
              frame_error <= 1'b1;
            end
            start_pending <= cs_fall_q;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_move_receiver.sv
// Self-checking bench for spi_move_receiver: directed vector table, random frames
// against a rule-level model, and clear/reset abort sequences.
module tb_spi_move_receiver;

  localparam int PH = 6;  // clk cycles per SPI phase

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] selected_col;
  logic       valid_move;
  logic       frame_error;
  logic       busy;

  int checks = 0;
  int failures = 0;

  spi_move_receiver dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .enable(enable), .clear(clear), .selected_col(selected_col),
    .valid_move(valid_move), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] bits;
    int         n;
    bit         en;
    bit         exp_v;
    bit         exp_e;
    logic [2:0] exp_col;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [8:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      wait_cycles(PH);
      spi_clk = 1'b1;
      wait_cycles(PH);
      spi_clk = 1'b0;
    end
  endtask

  // Rule-level reference: decide the outcome of a transmitted frame.
  function automatic void model(input logic [8:0] bits, input int n, input bit en,
                                output bit v, output bit e);
    logic [7:0] f;
    bit well;
    bit par;
    f = bits[7:0];
`ifdef SPI_PARITY_EN
    par = ($countones(f) % 2) == 1;
`else
    par = 1'b1;
`endif
    well = (n == 8) && (f[7:5] == 3'b101) && (f[1] == 1'b0) && (int'(f[4:2]) < 7) && par;
    v = well && en;
    e = !well;
  endfunction

  // Sends one frame, then watches the 8 cycles after CS rises.
  task automatic run_frame(input vec_t v, input string name);
    int vm_hit, vm_other, fe_hit, fe_other;
    logic busy4, busy5;
    vm_hit = 0; vm_other = 0; fe_hit = 0; fe_other = 0; busy4 = 0; busy5 = 0;
    enable = v.en;
    spi_cs = 1'b0;
    wait_cycles(PH);
    shift_bits(v.bits, v.n);
    wait_cycles(PH);
    check({name, "_busy_in_frame"}, 32'(busy), 32'd1);
    spi_cs = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        vm_hit += int'(valid_move);
        fe_hit += int'(frame_error);
      end else begin
        vm_other += int'(valid_move);
        fe_other += int'(frame_error);
      end
      if (k == 4) busy4 = busy;
      if (k == 5) busy5 = busy;
    end
    check({name, "_valid_at_lat"}, 32'(vm_hit), 32'(v.exp_v));
    check({name, "_valid_elsewhere"}, 32'(vm_other), 32'd0);
    check({name, "_error_at_lat"}, 32'(fe_hit), 32'(v.exp_e));
    check({name, "_error_elsewhere"}, 32'(fe_other), 32'd0);
    check({name, "_busy_check"}, 32'(busy4), 32'd1);
    check({name, "_busy_done"}, 32'(busy5), 32'd0);
    check({name, "_col"}, 32'(selected_col), 32'(v.exp_col));
    @(negedge clk);
    wait_cycles(PH);
  endtask

  // Watches a window in which nothing may happen.
  task automatic watch_quiet(input string name, input logic [2:0] exp_col);
    int pulses, busies;
    pulses = 0; busies = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      pulses += int'(valid_move) + int'(frame_error);
      busies += int'(busy);
    end
    check({name, "_no_pulse"}, 32'(pulses), 32'd0);
    check({name, "_no_busy"}, 32'(busies), 32'd0);
    check({name, "_col"}, 32'(selected_col), 32'(exp_col));
    @(negedge clk);
  endtask

  vec_t vecs[12];
  logic [2:0] model_col;

  initial begin
    vecs[0]  = '{9'h0AD, 8, 1'b1, 1'b1, 1'b0, 3'd3};  // 101_011_0_1
    vecs[1]  = '{9'h0BC, 8, 1'b1, 1'b0, 1'b1, 3'd3};  // column 7
    vecs[2]  = '{9'h02B, 6, 1'b1, 1'b0, 1'b1, 3'd3};  // short
    vecs[3]  = '{9'h1AD, 9, 1'b1, 1'b0, 1'b1, 3'd3};  // long
    vecs[4]  = '{9'h0A8, 8, 1'b0, 1'b0, 1'b0, 3'd3};  // col 2, disabled
    vecs[5]  = '{9'h0A8, 8, 1'b1, 1'b1, 1'b0, 3'd2};  // col 2, odd ones
`ifdef SPI_PARITY_EN
    vecs[6]  = '{9'h0A9, 8, 1'b1, 1'b0, 1'b1, 3'd2};  // even ones
`else
    vecs[6]  = '{9'h0A9, 8, 1'b1, 1'b1, 1'b0, 3'd2};
`endif
    vecs[7]  = '{9'h085, 8, 1'b1, 1'b0, 1'b1, 3'd2};  // bad header
    vecs[8]  = '{9'h0A7, 8, 1'b1, 1'b0, 1'b1, 3'd2};  // reserved bit set
    vecs[9]  = '{9'h0B9, 8, 1'b1, 1'b1, 1'b0, 3'd6};  // top legal column
    vecs[10] = '{9'h0A1, 8, 1'b1, 1'b1, 1'b0, 3'd0};  // column 0
    vecs[11] = '{9'h056, 7, 1'b0, 1'b0, 1'b1, 3'd0};  // short while disabled

    wait_cycles(3);
    check("reset_col", 32'(selected_col), 32'd0);
    check("reset_valid", 32'(valid_move), 32'd0);
    check("reset_error", 32'(frame_error), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    wait_cycles(10);

    for (int i = 0; i < 12; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    model_col = 3'd0;
    for (int i = 0; i < 25; i++) begin
      vec_t v;
      logic [7:0] f;
      logic [2:0] hdr;
      int r;
      hdr = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b101;
      f = {hdr, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), 1'b0};
      f[0] = ~(^f[7:1]);
      if ($urandom_range(0, 4) == 0) f[0] = ~f[0];
      r = $urandom_range(0, 9);
      v.n = (r == 0) ? 6 : (r == 1) ? 9 : 8;
      v.bits = (v.n == 9) ? {1'b1, f} : (v.n == 6) ? {3'b000, f[7:2]} : {1'b0, f};
      v.en = ($urandom_range(0, 4) != 0);
      model(v.bits, v.n, v.en, v.exp_v, v.exp_e);
      if (v.exp_v) model_col = f[4:2];
      v.exp_col = model_col;
      run_frame(v, $sformatf("rnd%0d", i));
    end

    // clear mid-frame
    enable = 1'b1;
    spi_cs = 1'b0;
    wait_cycles(PH);
    shift_bits(9'h00B, 4);
    clear = 1'b1;
    @(posedge clk); #1;
    check("clear_busy", 32'(busy), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    shift_bits(9'h005, 4);
    wait_cycles(PH);
    spi_cs = 1'b1;
    watch_quiet("clear_after", model_col);
    wait_cycles(PH);
    run_frame('{9'h0B5, 8, 1'b1, 1'b1, 1'b0, 3'd5}, "clear_next");

    // reset mid-frame, released while CS is still low
    spi_cs = 1'b0;
    wait_cycles(PH);
    shift_bits(9'h005, 3);
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_col", 32'(selected_col), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    shift_bits(9'h00D, 5);
    wait_cycles(PH);
    spi_cs = 1'b1;
    watch_quiet("rst_after", 3'd0);
    wait_cycles(PH);
    run_frame('{9'h0B0, 8, 1'b1, 1'b1, 1'b0, 3'd4}, "rst_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
